// File: rtl/sfx_sequencer.sv
// sfx_sequencer: walks a 16-entry note table and emits a 1-bit square wave.
// Each table byte holds a tone code [7:4] and a duration code [3:0].
// Tone 0 is a rest, tones 1..14 set the half-period, and tone 15 marks the end of the table.
// Every note is followed by a silent gap.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | silent, note_idx held at 0, waiting for trigger
// PLAY  | current entry sounding (or resting) for its duration
// GAP   | silent spacing after the current entry before the next load
module sfx_sequencer #(
  parameter int           CLK_HZ      = 100_000_000,
  parameter int           TICK_CYCLES = 6_250_000,
  parameter int           TONE_BASE   = 1_000,
  parameter int           GAP_CYCLES  = 500_000,
  parameter logic [127:0] SEQ         = 128'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       trigger,
  input  logic       loop,
  output logic       audio_out,
  output logic       busy,
  output logic [3:0] note_idx,
  output logic       done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // The +1 keeps each width at one bit or more and covers the full maximum count.
  localparam int DUR_W  = $clog2(16 * TICK_CYCLES + 1);
  localparam int HALF_W = $clog2(15 * TONE_BASE + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);

  function automatic logic [3:0] f_tone(input logic [3:0] idx);
    return SEQ[{idx, 3'd4} +: 4];
  endfunction

  function automatic logic [3:0] f_dcode(input logic [3:0] idx);
    return SEQ[{idx, 3'd0} +: 4];
  endfunction

  // A rest or end marker never toggles, so its half-period reload is simply 0.
  function automatic logic [HALF_W-1:0] f_half(input logic [3:0] tone);
    if (tone == 4'd0 || tone == 4'hF) return '0;
    return HALF_W'(TONE_BASE * (16 - int'(tone)) - 1);
  endfunction

  logic [1:0]        r_state;
  logic [3:0]        r_note_idx;
  logic              r_audio;
  logic              r_done;
  logic [DUR_W-1:0]  r_dur_cnt;
  logic [HALF_W-1:0] r_half_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;

  logic [3:0]        w_cur_tone;
  logic [HALF_W-1:0] w_cur_half;
  logic [3:0]        w_nxt_idx;
  logic              w_nxt_end;
  logic              w_e0_end;
  logic              w_load;
  logic [3:0]        w_ld_idx;
  logic              w_to_idle;
  logic              w_done_set;
  logic [3:0]        w_ld_tone;
  logic [3:0]        w_ld_dcode;
  logic [DUR_W-1:0]  w_ld_dur;
  logic [HALF_W-1:0] w_ld_half;

  assign w_cur_tone = f_tone(r_note_idx);
  assign w_cur_half = f_half(w_cur_tone);
  assign w_nxt_idx  = r_note_idx + 4'd1;
  assign w_nxt_end  = (r_note_idx == 4'hF) || (f_tone(w_nxt_idx) == 4'hF);
  assign w_e0_end   = (f_tone(4'd0) == 4'hF);

  assign w_ld_tone  = f_tone(w_ld_idx);
  assign w_ld_dcode = f_dcode(w_ld_idx);
  assign w_ld_dur   = DUR_W'((int'(w_ld_dcode) + 1) * TICK_CYCLES - 1);
  assign w_ld_half  = f_half(w_ld_tone);

  // Decide whether this cycle does one of three things: it loads an entry, it returns to IDLE, or the FSM keeps running.
  // Priority is enable, then trigger, then end of gap. Because trigger beats end of gap, a restart suppresses done.
  always_comb begin
    w_load     = 1'b0;
    w_ld_idx   = 4'd0;
    w_to_idle  = 1'b0;
    w_done_set = 1'b0;
    if (!enable) begin
      w_to_idle = 1'b1;
    end else if (trigger) begin
      if (w_e0_end) begin
        w_to_idle  = 1'b1;
        w_done_set = !loop;
      end else begin
        w_load = 1'b1;
      end
    end else if (r_state == S_GAP && r_gap_cnt == '0) begin
      if (!w_nxt_end) begin
        w_load   = 1'b1;
        w_ld_idx = w_nxt_idx;
      end else if (loop && !w_e0_end) begin
        w_load = 1'b1;
      end else begin
        w_to_idle  = 1'b1;
        w_done_set = !loop;
      end
    end
  end

  // Sequencer state, down-counters and the registered square-wave output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_note_idx <= 4'd0;
      r_audio    <= 1'b0;
      r_done     <= 1'b0;
      r_dur_cnt  <= '0;
      r_half_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_done <= w_done_set;
      if (w_to_idle) begin
        r_state    <= S_IDLE;
        r_note_idx <= 4'd0;
        r_audio    <= 1'b0;
        r_dur_cnt  <= '0;
        r_half_cnt <= '0;
        r_gap_cnt  <= '0;
      end else if (w_load) begin
        r_state    <= S_PLAY;
        r_note_idx <= w_ld_idx;
        r_audio    <= 1'b0;
        r_dur_cnt  <= w_ld_dur;
        r_half_cnt <= w_ld_half;
        r_gap_cnt  <= '0;
      end else begin
        case (r_state)
          S_PLAY: begin
            if (r_dur_cnt == '0) begin
              r_state    <= S_GAP;
              r_gap_cnt  <= GAP_RELOAD;
              r_audio    <= 1'b0;
              r_half_cnt <= '0;
            end else begin
              r_dur_cnt <= r_dur_cnt - DUR_W'(1);
              if (w_cur_tone != 4'd0) begin
                if (r_half_cnt == '0) begin
                  r_audio    <= ~r_audio;
                  r_half_cnt <= w_cur_half;
                end else begin
                  r_half_cnt <= r_half_cnt - HALF_W'(1);
                end
              end
            end
          end
          // The gap end (count 0) is always handled above as a load or an idle transition.
          S_GAP: r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          default: ;
        endcase
      end
    end
  end

  assign audio_out = r_audio;
  assign busy      = (r_state != S_IDLE);
  assign note_idx  = r_note_idx;
  assign done      = r_done;

endmodule
